// File: rtl/mesi_isc_pkg.sv
// Shared command/broadcast encodings and the per-port request entry type
// for the MESI intersection controller broadcast-request path.
package mesi_isc_pkg;

  localparam int unsigned MBUS_CMD_W   = 3;
  localparam int unsigned BROAD_TYPE_W = 2;
  localparam int unsigned BREQ_ADDR_W  = 32;

  localparam logic [MBUS_CMD_W-1:0] MBUS_CMD_NOP      = 3'd0;
  localparam logic [MBUS_CMD_W-1:0] MBUS_CMD_RD       = 3'd1;
  localparam logic [MBUS_CMD_W-1:0] MBUS_CMD_WR       = 3'd2;
  localparam logic [MBUS_CMD_W-1:0] MBUS_CMD_WR_BROAD = 3'd3;
  localparam logic [MBUS_CMD_W-1:0] MBUS_CMD_RD_BROAD = 3'd4;

  localparam logic [BROAD_TYPE_W-1:0] BROAD_TYPE_NOP = 2'd0;
  localparam logic [BROAD_TYPE_W-1:0] BROAD_TYPE_WR  = 2'd1;
  localparam logic [BROAD_TYPE_W-1:0] BROAD_TYPE_RD  = 2'd2;

  typedef struct packed {
    logic [BREQ_ADDR_W-1:0]  addr;
    logic [BROAD_TYPE_W-1:0] btype;
  } breq_entry_t;

  function automatic logic is_broad_cmd(input logic [MBUS_CMD_W-1:0] cmd);
    return (cmd == MBUS_CMD_WR_BROAD) || (cmd == MBUS_CMD_RD_BROAD);
  endfunction

  function automatic logic [BROAD_TYPE_W-1:0] mbus_to_broad_type(input logic [MBUS_CMD_W-1:0] cmd);
    case (cmd)
      MBUS_CMD_WR_BROAD: return BROAD_TYPE_WR;
      MBUS_CMD_RD_BROAD: return BROAD_TYPE_RD;
      default:           return BROAD_TYPE_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mesi_isc_breq_port_fifo.sv
// Per-CPU request FIFO: power-of-two circular buffer whose pointers wrap
// naturally; push into a full FIFO and pop from an empty one are ignored.
module mesi_isc_breq_port_fifo
  import mesi_isc_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DEPTH_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  breq_entry_t push_data,
  input  logic        pop,
  output breq_entry_t head,
  output logic        empty,
  output logic        full
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  breq_entry_t           mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: only entries counted as valid are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mesi_isc_breq_arb_n.sv
// N-CPU broadcast-request collector: per-port request FIFOs, round-robin
// drain into the broadcast FIFO, and a broadcast ID counter skipping 0.
module mesi_isc_breq_arb_n
  import mesi_isc_pkg::*;
#(
  parameter int unsigned NUM_CPUS         = 4,
  parameter int unsigned CPU_ID_WIDTH     = 2,
  parameter int unsigned MBUS_CMD_WIDTH   = 3,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned BROAD_TYPE_WIDTH = 2,
  parameter int unsigned BROAD_ID_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH       = 2,
  parameter int unsigned FIFO_DEPTH_LOG2  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
  input  logic [NUM_CPUS*ADDR_WIDTH-1:0]     mbus_addr_array_i,
  input  logic                               broad_fifo_status_full_i,
  output logic [NUM_CPUS-1:0]                mbus_ack_array_o,
  output logic                               broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]              broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]        broad_type_o,
  output logic [CPU_ID_WIDTH-1:0]            broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]          broad_id_o,
  output logic [NUM_CPUS-1:0]                port_full_o
);

  logic [NUM_CPUS-1:0]       push;
  logic [NUM_CPUS-1:0]       pop;
  logic [NUM_CPUS-1:0]       empty;
  logic [NUM_CPUS-1:0]       full;
  breq_entry_t               push_data [NUM_CPUS];
  breq_entry_t               head      [NUM_CPUS];
  breq_entry_t               head_sel;

  logic [CPU_ID_WIDTH-1:0]   rr_ptr;
  logic [CPU_ID_WIDTH-1:0]   rr_next;
  logic [CPU_ID_WIDTH-1:0]   winner;
  logic [BROAD_ID_WIDTH-1:0] id_cnt;
  logic [BROAD_ID_WIDTH-1:0] id_next;
  logic [31:0]               idx;
  logic                      found;
  logic                      do_pop;

  // Accept gate: last cycle's ack blocks re-capturing a still-held command.
  for (genvar k = 0; k < NUM_CPUS; k++) begin : g_port
    logic [MBUS_CMD_W-1:0] cmd;

    assign cmd                = MBUS_CMD_W'(mbus_cmd_array_i[k*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]);
    assign push[k]            = is_broad_cmd(cmd) && !full[k] && !mbus_ack_array_o[k];
    assign push_data[k].addr  = BREQ_ADDR_W'(mbus_addr_array_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
    assign push_data[k].btype = mbus_to_broad_type(cmd);

    mesi_isc_breq_port_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (push[k]),
      .push_data (push_data[k]),
      .pop       (pop[k]),
      .head      (head[k]),
      .empty     (empty[k]),
      .full      (full[k])
    );
  end

  assign port_full_o = full;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_CPUS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      idx = 32'(rr_ptr) + 32'(i);
      if (idx >= NUM_CPUS) idx = idx - NUM_CPUS;
      if (!found && !empty[idx[CPU_ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[CPU_ID_WIDTH-1:0];
      end
    end
    do_pop   = found && !broad_fifo_status_full_i;
    pop      = '0;
    if (do_pop) pop[winner] = 1'b1;
    head_sel = head[winner];
    rr_next  = (winner == CPU_ID_WIDTH'(NUM_CPUS - 1)) ? '0 : winner + CPU_ID_WIDTH'(1);
    id_next  = (id_cnt == '1) ? BROAD_ID_WIDTH'(1) : id_cnt + BROAD_ID_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mbus_ack_array_o <= '0;
      broad_fifo_wr_o  <= 1'b0;
      broad_addr_o     <= '0;
      broad_type_o     <= '0;
      broad_cpu_id_o   <= '0;
      broad_id_o       <= '0;
      rr_ptr           <= '0;
      id_cnt           <= BROAD_ID_WIDTH'(1);
    end else begin
      mbus_ack_array_o <= push;
      broad_fifo_wr_o  <= do_pop;
      if (do_pop) begin
        broad_addr_o   <= ADDR_WIDTH'(head_sel.addr);
        broad_type_o   <= BROAD_TYPE_WIDTH'(head_sel.btype);
        broad_cpu_id_o <= winner;
        broad_id_o     <= id_cnt;
        rr_ptr         <= rr_next;
        id_cnt         <= id_next;
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_breq_arb_n.sv
// Bench for mesi_isc_breq_arb_n: queue-based behavioural model plus directed
// scenarios and a randomized soak.
module tb_mesi_isc_breq_arb_n;

  localparam int N     = 4;
  localparam int CW    = 3;
  localparam int AW    = 32;
  localparam int TW    = 2;
  localparam int CIW   = 2;
  localparam int IW    = 5;
  localparam int DEPTH = 2;
  localparam int VW    = N + 1 + AW + TW + CIW + IW + N;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*CW-1:0] cmd_vec;
  logic [N*AW-1:0] addr_vec;
  logic            bfull;
  logic [N-1:0]    ack;
  logic            wr;
  logic [AW-1:0]   baddr;
  logic [TW-1:0]   btype;
  logic [CIW-1:0]  bcpu;
  logic [IW-1:0]   bid;
  logic [N-1:0]    pfull;

  always #5 clk = ~clk;

  mesi_isc_breq_arb_n dut (
    .clk                      (clk),
    .rst                      (rst),
    .mbus_cmd_array_i         (cmd_vec),
    .mbus_addr_array_i        (addr_vec),
    .broad_fifo_status_full_i (bfull),
    .mbus_ack_array_o         (ack),
    .broad_fifo_wr_o          (wr),
    .broad_addr_o             (baddr),
    .broad_type_o             (btype),
    .broad_cpu_id_o           (bcpu),
    .broad_id_o               (bid),
    .port_full_o              (pfull)
  );

  // Bus masters: broadcast commands are held until acked, others last as told.
  logic [CW-1:0] req_cmd   [N];
  logic [AW-1:0] req_addr  [N];
  bit            req_hold  [N];
  bit            req_valid [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      cmd_vec[k*CW +: CW]  = req_valid[k] ? req_cmd[k] : '0;
      addr_vec[k*AW +: AW] = req_addr[k];
    end
  end

  // Reference model: one queue per CPU, plain integer round-robin and ID.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [TW-1:0] t;
  } ent_t;

  ent_t          mq [N][$];
  int            rr_m, id_m;
  logic [N-1:0]  e_ack, e_full;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [TW-1:0] e_type;
  int            e_cpu, e_id;
  int            checks = 0;
  int            errors = 0;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) mq[k].delete();
    rr_m = 0; id_m = 1;
    e_ack = '0; e_full = '0; e_wr = 1'b0; e_addr = '0; e_type = '0; e_cpu = 0; e_id = 0;
  endfunction

  function automatic void model_step();
    logic [N-1:0]  nack;
    logic [CW-1:0] c [N];
    int            win;
    ent_t          e;
    if (!rst) begin
      model_reset();
      return;
    end
    win = -1;
    if (!bfull)
      for (int i = 0; i < N; i++)
        if (win < 0 && mq[(rr_m + i) % N].size() > 0) win = (rr_m + i) % N;
    for (int k = 0; k < N; k++) begin
      c[k]    = req_valid[k] ? req_cmd[k] : '0;
      nack[k] = (c[k] == 3 || c[k] == 4) && mq[k].size() < DEPTH && !e_ack[k];
    end
    if (win >= 0) begin
      e      = mq[win].pop_front();
      e_wr   = 1'b1;
      e_addr = e.a;
      e_type = e.t;
      e_cpu  = win;
      e_id   = id_m;
      rr_m   = (win + 1) % N;
      id_m   = id_m % ((1 << IW) - 1) + 1;
    end else begin
      e_wr = 1'b0;
    end
    for (int k = 0; k < N; k++)
      if (nack[k]) mq[k].push_back(ent_t'{a: req_addr[k], t: (c[k] == 3) ? 2'd1 : 2'd2});
    e_ack = nack;
    for (int k = 0; k < N; k++) e_full[k] = (mq[k].size() == DEPTH);
  endfunction

  function automatic logic [VW-1:0] obs();
    return {ack, wr, baddr, btype, bcpu, bid, pfull};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {e_ack, e_wr, e_addr, e_type, CIW'(e_cpu), IW'(e_id), e_full};
  endfunction

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (req_valid[k] && (e_ack[k] || !req_hold[k])) req_valid[k] = 1'b0;
  endtask

  task automatic issue(input int k, input logic [CW-1:0] c, input logic [AW-1:0] a, input bit hold);
    req_cmd[k] = c; req_addr[k] = a; req_hold[k] = hold; req_valid[k] = 1'b1;
  endtask

  task automatic clear_masters();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_hold[k] = 1'b0; req_cmd[k] = '0; req_addr[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_async dut=%h want=0", obs());
    end
    run_cycle();
    rst = 1'b1;
    bfull = 1'b0;
    clear_masters();
  endtask

  task automatic test_reset();
    rst = 1'b0; bfull = 1'b0;
    clear_masters();
    model_reset();
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_state dut=%h want=0", obs());
    end
    @(negedge clk);
    rst = 1'b1;
    run_cycle();
    checks++;
    if (obs() !== expv() || pfull !== '0 || wr !== 1'b0) begin
      errors++; $display("FAIL reset_idle dut=%h model=%h", obs(), expv());
    end
  endtask

  task automatic test_single();
    int acks;
    do_reset();
    issue(2, 3'd4, 32'h1000, 1'b1);
    run_cycle();
    checks++;
    if (ack !== 4'b0100 || wr !== 1'b0) begin
      errors++; $display("FAIL single_ack ack=%b wr=%b want ack=0100 wr=0", ack, wr);
    end
    acks = 1;
    run_cycle();
    checks++;
    if (obs() !== {4'b0000, 1'b1, 32'h1000, 2'd2, 2'd2, 5'd1, 4'b0000}) begin
      errors++; $display("FAIL single_wr dut=%h want wr=1 addr=1000 type=2 cpu=2 id=1", obs());
    end
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      if (ack[2]) acks++;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single_model dut=%h model=%h", obs(), expv());
      end
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL single_ack_count got=%0d want=1", acks);
    end
  endtask

  task automatic test_simultaneous();
    int cpus[$];
    int ids[$];
    do_reset();
    for (int k = 0; k < N; k++) issue(k, 3'd3, 32'hA0 + 32'(k) * 32'h100, 1'b1);
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      if (wr) begin cpus.push_back(int'(bcpu)); ids.push_back(int'(bid)); end
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL simul_model dut=%h model=%h", obs(), expv());
      end
    end
    checks++;
    if (cpus.size() != 4 || cpus[0] != 0 || cpus[1] != 1 || cpus[2] != 2 || cpus[3] != 3 ||
        ids[0] != 1 || ids[1] != 2 || ids[2] != 3 || ids[3] != 4) begin
      errors++; $display("FAIL simul_order cpus=%p ids=%p want 0,1,2,3 ids 1..4", cpus, ids);
    end
    cpus.delete(); ids.delete();
    issue(3, 3'd4, 32'h33, 1'b1);
    issue(0, 3'd3, 32'h11, 1'b1);
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (wr) begin cpus.push_back(int'(bcpu)); ids.push_back(int'(bid)); end
    end
    checks++;
    if (cpus.size() != 2 || cpus[0] != 0 || cpus[1] != 3 || ids[0] != 5 || ids[1] != 6) begin
      errors++; $display("FAIL simul_second cpus=%p ids=%p want 0,3 ids 5,6", cpus, ids);
    end
  endtask

  task automatic test_back_pressure();
    int n_req, acks, first_pop, third_ack, writes;
    do_reset();
    bfull = 1'b1;
    n_req = 0; acks = 0;
    for (int c = 0; c < 10; c++) begin
      if (!req_valid[1] && n_req < 3) begin
        issue(1, 3'd3, 32'h2000 + 32'(n_req) * 4, 1'b1);
        n_req++;
      end
      run_cycle();
      if (ack[1]) acks++;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL bp_hold_model dut=%h model=%h", obs(), expv());
      end
    end
    checks++;
    if (acks != 2 || pfull !== 4'b0010 || wr !== 1'b0) begin
      errors++; $display("FAIL bp_blocked acks=%0d full=%b wr=%b want 2/0010/0", acks, pfull, wr);
    end
    bfull = 1'b0;
    first_pop = -1; third_ack = -1; writes = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      if (wr) begin
        writes++;
        if (first_pop < 0) first_pop = c;
      end
      if (ack[1] && third_ack < 0) third_ack = c;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL bp_release_model dut=%h model=%h", obs(), expv());
      end
    end
    checks++;
    if (first_pop < 0 || third_ack < first_pop || third_ack - first_pop > 2 || writes != 3 || bid !== 5'd3) begin
      errors++; $display("FAIL bp_resume pop=%0d ack3=%0d writes=%0d id=%0d want ack within 2, 3 writes, id 3",
                         first_pop, third_ack, writes, bid);
    end
  endtask

  task automatic test_id_wrap();
    int writes;
    do_reset();
    writes = 0;
    for (int c = 0; c < 400 && writes < 33; c++) begin
      for (int k = 0; k < N; k++)
        if (!req_valid[k]) issue(k, ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4, $urandom, 1'b1);
      run_cycle();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL wrap_model dut=%h model=%h", obs(), expv());
      end
      if (wr) begin
        checks++;
        if (bid !== IW'(writes % 31 + 1) || bid === '0) begin
          errors++; $display("FAIL wrap_id n=%0d got=%0d want=%0d", writes, bid, writes % 31 + 1);
        end
        writes++;
      end
    end
    checks++;
    if (writes != 33) begin
      errors++; $display("FAIL wrap_timeout writes=%0d want=33", writes);
    end
  endtask

  task automatic test_non_broadcast();
    for (int k = 0; k < N; k++) issue(k, CW'($urandom_range(1, 2)), $urandom, 1'b1);
    do_reset();
    for (int k = 0; k < N; k++) issue(k, CW'($urandom_range(1, 2)), $urandom, 1'b1);
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      checks++;
      if (ack !== '0 || wr !== 1'b0 || obs() !== expv()) begin
        errors++; $display("FAIL nonbroad ack=%b wr=%b want ack=0 wr=0", ack, wr);
      end
    end
    clear_masters();
  endtask

  task automatic test_reset_mid();
    int writes;
    do_reset();
    bfull = 1'b1;
    issue(0, 3'd3, 32'h10, 1'b1);
    issue(1, 3'd4, 32'h20, 1'b1);
    issue(2, 3'd3, 32'h30, 1'b1);
    for (int c = 0; c < 3; c++) run_cycle();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL rstmid_async dut=%h want=0", obs());
    end
    run_cycle();
    rst = 1'b1; bfull = 1'b0;
    clear_masters();
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      checks++;
      if (wr !== 1'b0 || obs() !== expv()) begin
        errors++; $display("FAIL rstmid_idle dut=%h model=%h", obs(), expv());
      end
    end
    issue(3, 3'd4, 32'hBEEF0, 1'b1);
    writes = 0;
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      if (wr) begin
        writes++;
        checks++;
        if (bid !== 5'd1 || bcpu !== 2'd3 || baddr !== 32'hBEEF0) begin
          errors++; $display("FAIL rstmid_first id=%0d cpu=%0d addr=%h want 1/3/beef0", bid, bcpu, baddr);
        end
      end
    end
    checks++;
    if (writes != 1) begin
      errors++; $display("FAIL rstmid_writes got=%0d want=1", writes);
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] c;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bfull = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++)
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          c = CW'($urandom_range(0, 7));
          issue(k, c, $urandom, (c == 3'd3 || c == 3'd4));
        end
      run_cycle();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random n=%0d dut=%h model=%h", n, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_id_wrap();
    test_non_broadcast();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_isc_breq_arb_n.md
Name: mesi_isc_breq_arb_n

Overview:
N-CPU broadcast-request collector for the MESI intersection controller. Generalises the fixed 4-CPU request front end to NUM_CPUS ports, each with a parametrised-depth request FIFO. It adds round-robin arbitration with back-pressure, and a broadcast ID generator that reserves ID 0. It sits between the per-CPU main-bus command inputs and the broadcast FIFO write port.

Parameters:
NUM_CPUS, 4, number of CPU main-bus ports (2..16)
CPU_ID_WIDTH, 2, width of broad_cpu_id_o; must equal clog2(NUM_CPUS), minimum 1
MBUS_CMD_WIDTH, 3, main-bus command width
ADDR_WIDTH, 32, address width
BROAD_TYPE_WIDTH, 2, broadcast type width
BROAD_ID_WIDTH, 5, broadcast ID width
FIFO_DEPTH, 2, entries per port FIFO (power of two, ≥2)
FIFO_DEPTH_LOG2, 1, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
mbus_cmd_array_i  in  NUM_CPUS*MBUS_CMD_WIDTH  per-CPU command; CPU k in slice k
mbus_addr_array_i  in  NUM_CPUS*ADDR_WIDTH  per-CPU address; CPU k in slice k
broad_fifo_status_full_i  in  1  downstream broadcast FIFO full
mbus_ack_array_o  out  NUM_CPUS  per-CPU accept pulse
broad_fifo_wr_o  out  1  broadcast write strobe
broad_addr_o  out  ADDR_WIDTH  broadcast address
broad_type_o  out  BROAD_TYPE_WIDTH  broadcast type
broad_cpu_id_o  out  CPU_ID_WIDTH  originating CPU
broad_id_o  out  BROAD_ID_WIDTH  broadcast ID
port_full_o  out  NUM_CPUS  per-port FIFO full status

Behaviour:
- Reset (rst=0, async): all FIFOs empty, all outputs 0, port_full_o=0, rr_ptr=0, ID counter=1.
- Command codes: MBUS_CMD_WR_BROAD=3 maps to BROAD_TYPE_WR=1. MBUS_CMD_RD_BROAD=4 maps to BROAD_TYPE_RD=2. All other codes (NOP, RD, WR) are ignored and never acked.
- Accept rule for port k: the port is accepted when all three hold: cmd_k is a broadcast code, port FIFO k is not full, and ack_k was 0 in the previous cycle. On acceptance:
  - push {addr, type} into FIFO k;
  - mbus_ack_k=1 for exactly one cycle, registered, so it appears the cycle after sampling.
- Masters hold cmd until ack. The previous-cycle ack gate stops a held command from being captured twice.
- A full FIFO blocks push even when the same FIFO is popped in that cycle. The port retries on the next cycle.
- Arbitration runs every cycle when broad_fifo_status_full_i=0 and at least one FIFO is non-empty:
  - winner = first non-empty port scanning rr_ptr, rr_ptr+1, … modulo NUM_CPUS;
  - the winner's head entry is popped;
  - next cycle: broad_fifo_wr_o=1, with addr/type/cpu_id=winner/id=counter;
  - rr_ptr <= (winner+1) mod NUM_CPUS; the counter increments.
- When no pop occurs, broad_fifo_wr_o=0 and the data outputs hold their last values. rr_ptr and the counter are unchanged.
- When broad_fifo_status_full_i=1 there is no pop that cycle. A write already registered still completes. Downstream full has one cycle of slack.
- ID counter wraps from 2^BROAD_ID_WIDTH-1 to 1. ID 0 is never issued.
- Latency: command sampled at edge t, ack high t+1, entry visible in FIFO t+1. Earliest broad_fifo_wr_o is t+2.
- port_full_o[k] is registered, equal to FIFO k count==FIFO_DEPTH.
- Reset asserted mid-operation discards all queued entries. No pending ack or write survives.

Decomposition:
- Package mesi_isc_pkg holds:
  - MBUS_CMD_* and BROAD_TYPE_* constants;
  - typedef breq_entry_t {addr, type};
  - function mbus_to_broad_type().
- Sub-module mesi_isc_breq_port_fifo (one per port, generate loop): depth-parametrised circular buffer with push/pop, full/empty, and wrap-around pointers.
- The round-robin scan stays in the top module.

Test Plan:
- Single request: CPU2 holds cmd=4 (RD_BROAD), addr=0x1000 -> ack2 pulses exactly once. broad_fifo_wr_o=1 two cycles after first sample, with addr=0x1000, type=2, cpu_id=2, id=1.
- Simultaneous: all 4 CPUs issue cmd=3 in the same cycle -> four consecutive writes, cpu_id order 0,1,2,3, ids 1..4. Then CPU0 and CPU3 again -> order 0,3 (rr_ptr=0 after cpu 3).
- Back-pressure: CPU1 issues 3 requests while broad_fifo_status_full_i=1 -> first 2 acked, port_full_o[1]=1, third ack withheld. Release full -> writes resume, third ack follows within 2 cycles of the first pop.
- ID wrap: 31 broadcasts, then 2 more -> ids ...,30,31,1,2. Value 0 never appears.
- Non-broadcast: cmd=1/2 held 10 cycles -> no ack, no write.
- Reset mid-operation: assert rst=0 with 3 entries queued -> next cycles show all outputs 0. After release there are no writes until new commands arrive, and the first id is 1.
